// File: rtl/imm_pkg.sv
// Shared opcode constants and immediate-class encoding for the
// immediate decode stage and its class decoder.
package imm_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    localparam int IMM_CLASS_W = 2;

    typedef enum logic [IMM_CLASS_W-1:0] {
        IMM_I     = 2'b00,
        IMM_SHIFT = 2'b01,
        IMM_STORE = 2'b10,
        IMM_UPPER = 2'b11
    } imm_class_e;

endpackage

// File: rtl/imm_class_dec.sv
// Combinational opcode-to-immediate decoder: selects the immediate class
// and builds the sign/zero-extended immediate for one instruction.
module imm_class_dec
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32
) (
    input  logic [INST_WIDTH-1:0] inst,
    output logic [DATA_WIDTH-1:0] imm,
    output imm_class_e            imm_class,
    output logic                  has_imm
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;

    assign opcode_s = inst[6:0];
    assign funct3_s = inst[14:12];

    // Class select and immediate assembly; unknown opcodes leave all-zero defaults
    always_comb begin
        imm       = '0;
        imm_class = IMM_I;
        has_imm   = 1'b0;
        case (opcode_s)
            OP_LOAD, OP_JALR: begin
                imm       = {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]};
                imm_class = IMM_I;
                has_imm   = 1'b1;
            end
            OP_IMM, OP_IMM_32: begin
                if ((funct3_s == F3_SLL) || (funct3_s == F3_SRX)) begin
                    imm       = {{(DATA_WIDTH-6){1'b0}}, inst[25:20]};
                    imm_class = IMM_SHIFT;
                end else begin
                    imm       = {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]};
                    imm_class = IMM_I;
                end
                has_imm = 1'b1;
            end
            OP_STORE: begin
                imm       = {{(DATA_WIDTH-12){inst[31]}}, inst[31:25], inst[11:7]};
                imm_class = IMM_STORE;
                has_imm   = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm       = {{(DATA_WIDTH-32){inst[31]}}, inst[31:12], 12'b0};
                imm_class = IMM_UPPER;
                has_imm   = 1'b1;
            end
            default: begin
                imm       = '0;
                imm_class = IMM_I;
                has_imm   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage: decodes at enqueue into a 2-entry
// in-order FIFO and counts output backpressure cycles.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int INST_WIDTH     = 32,
    parameter int IMM_TYPE_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INST_WIDTH-1:0]     in_inst,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INST_WIDTH-1:0]     out_inst,
    output logic [DATA_WIDTH-1:0]     out_pc,
    output logic [DATA_WIDTH-1:0]     out_imm,
    output logic [IMM_TYPE_WIDTH-1:0] out_imm_type,
    output logic                      out_has_imm,
    output logic [15:0]               out_stall_cnt
);

    logic [INST_WIDTH-1:0]     inst_mem_r [2];
    logic [DATA_WIDTH-1:0]     pc_mem_r   [2];
    logic [DATA_WIDTH-1:0]     imm_mem_r  [2];
    logic [IMM_TYPE_WIDTH-1:0] type_mem_r [2];
    logic                      has_mem_r  [2];

    logic [1:0]  count_r;
    logic [1:0]  count_next_s;
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [15:0] stall_cnt_r;
    logic        push_s;
    logic        pop_s;

    logic [DATA_WIDTH-1:0] dec_imm_s;
    imm_class_e            dec_class_s;
    logic                  dec_has_s;

    imm_class_dec #(
        .DATA_WIDTH (DATA_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_dec (
        .inst      (in_inst),
        .imm       (dec_imm_s),
        .imm_class (dec_class_s),
        .has_imm   (dec_has_s)
    );

    // Handshakes and next occupancy; flush wins over any push or pop
    always_comb begin
        push_s       = in_valid && in_ready_r;
        pop_s        = out_valid_r && out_ready;
        count_next_s = count_r;
        if (flush) begin
            count_next_s = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + 2'd1;
                2'b01:   count_next_s = count_r - 2'd1;
                default: count_next_s = count_r;
            endcase
        end
    end

    // Occupancy, pointers, and the registered ready/valid flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= 2'd0;
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            count_r     <= count_next_s;
            in_ready_r  <= (count_next_s != 2'd2);
            out_valid_r <= (count_next_s != 2'd0);
            if (flush) begin
                wr_ptr_r <= 1'b0;
                rd_ptr_r <= 1'b0;
            end else begin
                if (push_s) wr_ptr_r <= ~wr_ptr_r;
                if (pop_s)  rd_ptr_r <= ~rd_ptr_r;
            end
        end
    end

    // Entry storage, written with the decoded immediate at enqueue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                inst_mem_r[i] <= '0;
                pc_mem_r[i]   <= '0;
                imm_mem_r[i]  <= '0;
                type_mem_r[i] <= '0;
                has_mem_r[i]  <= 1'b0;
            end
        end else if (!flush && push_s) begin
            inst_mem_r[wr_ptr_r] <= in_inst;
            pc_mem_r[wr_ptr_r]   <= in_pc;
            imm_mem_r[wr_ptr_r]  <= dec_imm_s;
            type_mem_r[wr_ptr_r] <= IMM_TYPE_WIDTH'(dec_class_s);
            has_mem_r[wr_ptr_r]  <= dec_has_s;
        end
    end

    // Saturating backpressure counter; flush deliberately leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'd0;
        end else if (out_valid_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign out_stall_cnt = stall_cnt_r;
    assign out_inst      = inst_mem_r[rd_ptr_r];
    assign out_pc        = pc_mem_r[rd_ptr_r];
    assign out_imm       = imm_mem_r[rd_ptr_r];
    assign out_imm_type  = type_mem_r[rd_ptr_r];
    assign out_has_imm   = has_mem_r[rd_ptr_r];

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, datapath/immediate width.
REQ-002 SHALL have parameter INST_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter IMM_TYPE_WIDTH, default 2, immediate-class select width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low. Ports: clk  input  1  clock; rst_n  input  1  async active-low reset.
REQ-005 SHALL have flush  input  1  sync pipeline flush.
REQ-006 SHALL have in_valid  input  1; in_ready  output  1; in_inst  input  INST_WIDTH; in_pc  input  DATA_WIDTH.
REQ-007 SHALL have out_valid  output  1; out_ready  input  1; out_inst  output  INST_WIDTH; out_pc  output  DATA_WIDTH.
REQ-008 SHALL have out_imm  output  DATA_WIDTH; out_imm_type  output  IMM_TYPE_WIDTH; out_has_imm  output  1.
REQ-009 SHALL have out_stall_cnt  output  16  saturating backpressure-cycle count.

Function
REQ-010 SHALL accept an entry on a rising edge with in_valid && in_ready; SHALL present it on a rising edge with out_valid && out_ready.
REQ-011 SHALL buffer accepted entries in a 2-entry in-order FIFO (wr_ptr, rd_ptr, 2-bit count); outputs SHALL come from the head entry.
REQ-012 in_ready SHALL be a function of registered state only (count < 2 and not in reset); no combinational path out_ready -> in_ready.
REQ-013 out_valid SHALL equal (count != 0); latency accept-edge to out_valid high SHALL be one cycle.
REQ-014 Decode (opcode inst[6:0]) SHALL occur at enqueue; imm, imm_type, has_imm SHALL be stored with the entry.
REQ-015 Class 00 (opcodes 0000011, 1100111, and 0010011/0011011 with funct3 not 001/101): imm = sign-extend inst[31:20].
REQ-016 Class 01 (0010011/0011011 with funct3 001 or 101): imm = zero-extend inst[25:20].
REQ-017 Class 10 (0100011): imm = sign-extend {inst[31:25], inst[11:7]}.
REQ-018 Class 11 (0110111, 0010111): imm = sign-extend {inst[31:12], 12'b0}.
REQ-019 Any other opcode: has_imm = 0, imm_type = 00, imm = 0; otherwise has_imm = 1.
REQ-020 Simultaneous push and pop at count 1 SHALL leave count 1 and keep order; push at count 0 with out_ready high SHALL not bypass (entry appears next cycle).
REQ-021 Pointers SHALL wrap modulo 2.
REQ-022 flush SHALL take priority: count, wr_ptr, rd_ptr -> 0 on that edge; any same-edge push or pop is discarded; out_valid low next cycle.
REQ-023 out_stall_cnt SHALL increment on each edge with out_valid && !out_ready, saturate at 0xFFFF, and be unaffected by flush.

Reset
REQ-024 While rst_n low: count, pointers, out_stall_cnt = 0; out_valid = 0; in_ready = 0.
REQ-025 Storage SHALL reset to 0, so out_inst, out_pc, out_imm, out_imm_type, out_has_imm read 0 after reset.
REQ-026 in_ready SHALL rise on the first clk edge after rst_n deasserts; reset mid-transfer SHALL drop all buffered entries.

Structure
REQ-027 Opcode constants, funct3 shift codes, and an imm_class_e enum (I, SHIFT, STORE, UPPER) SHALL live in a shared package imm_pkg.
REQ-028 Opcode-to-class/immediate decode SHALL be one combinational sub-module imm_class_dec; FIFO and counters stay in imm_decode_stage.

Verification
REQ-029 addi x1,x0,-1 (0xFFF00093) accepted -> next cycle out_valid=1, out_imm_type=00, out_imm=0xFFFFFFFFFFFFFFFF, out_has_imm=1.
REQ-030 sd x1,8(x2) (0x00113423) -> out_imm_type=10, out_imm=8; slli x1,x1,63 (0x03F09093) -> out_imm_type=01, out_imm=63.
REQ-031 lui x5,0x80000 (0x800002B7) -> out_imm_type=11, out_imm=0xFFFFFFFF80000000; add (0x003100B3) -> out_has_imm=0, out_imm=0.
REQ-032 out_ready=0, in_valid held with 3 instructions -> two accepted, in_ready=0, out_stall_cnt counts stalled cycles; out_ready=1 -> drains in original order, third accepted.
REQ-033 count=2 and in_valid=1 with flush=1 -> next cycle out_valid=0, in_ready=1, pushed entry absent, out_stall_cnt unchanged.
REQ-034 rst_n pulsed low with count=1 -> out_valid=0, in_ready=0 during reset, outputs 0; in_ready=1 one edge after release.
